// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the packet-atomic FIFO write arbiter:
// FSM state encoding and the width of the owner index.
package fifo_arb_pkg;

  localparam int GRANT_ID_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found scanning upward from (last_owner + 1) mod NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [GRANT_ID_W-1:0] last_owner_i,
  output logic                  valid_o,
  output logic [GRANT_ID_W-1:0] idx_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    valid_o = 1'b0;
    idx_o   = '0;
    // Walk offsets from farthest to nearest; the last hit is the nearest one.
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(last_owner_i) + off) % NUM_REQ && req_i[i]) begin
          valid_o = 1'b1;
          idx_o   = GRANT_ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ packet producers onto one shared FIFO write port,
// holding each grant until the owner's last word is written.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [GRANT_ID_W-1:0]         grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_count
);

  localparam logic [GRANT_ID_W-1:0] RESET_OWNER = GRANT_ID_W'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [GRANT_ID_W-1:0] grant_q, grant_d;
  logic [GRANT_ID_W-1:0] last_owner_q, last_owner_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  logic                  pick_valid;
  logic [GRANT_ID_W-1:0] pick_idx;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i        (req_valid),
    .last_owner_i (last_owner_q),
    .valid_o      (pick_valid),
    .idx_o        (pick_idx)
  );

  // Select the current owner's valid/last/data lanes.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GRANT_ID_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_owner_q <= RESET_OWNER;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = pick_idx;
        end
      end
      GRANT: begin
        // Only a written last word ends the packet; req_last alone does not.
        if (fifo_wr && own_last) begin
          state_d      = IDLE;
          last_owner_d = grant_q;
          pkt_count_d  = pkt_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = '0;
    if (state_q == GRANT && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == GRANT_ID_W'(i)) req_ready[i] = !fifo_full;
      end
      fifo_wr  = own_valid && !fifo_full;
      fifo_din = own_data;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q == GRANT);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-port word queues feed the
// producers, a small FIFO model collects writes, expectations are hand-built.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int DW         = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int RAND_WORDS = 1000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [DW-1:0]         fifo_din;
  logic [GRANT_ID_W-1:0] grant_id;
  logic                  busy;
  logic [15:0]           pkt_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int            n_vec  = 0;
  int            n_miss = 0;
  logic [DW-1:0] src_q       [NUM_REQ][$];
  bit            src_last_q  [NUM_REQ][$];
  bit            src_first_q [NUM_REQ][$];
  bit            hold        [NUM_REQ];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            rst_cmd = 1'b1;
  bit            rand_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] word(input int p, input int k, input int w);
    return {8'(p), 12'(k), 12'(w)};
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < NUM_REQ; p++) if (src_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_pkt(input int p, input int k, input int len, input bit to_exp);
    for (int w = 0; w < len; w++) begin
      src_q[p].push_back(word(p, k, w));
      src_last_q[p].push_back(w == len - 1);
      src_first_q[p].push_back(w == 0);
      if (to_exp) exp_q.push_back(word(p, k, w));
    end
  endtask

  // One clock: drive inputs after the edge, sample mid-cycle, retire handshakes.
  task automatic step();
    logic [DW-1:0] rd_word;
    @(posedge clk);
    #1;
    rst = rst_cmd;
    for (int p = 0; p < NUM_REQ; p++) begin
      bit v;
      v = (src_q[p].size() > 0) && !hold[p];
      if (v && rand_on && !src_first_q[p][0] && $urandom_range(3, 0) == 0) v = 1'b0;
      req_valid[p]         = v;
      req_data[p*DW +: DW] = v ? src_q[p][0] : '0;
      req_last[p]          = v ? src_last_q[p][0] : 1'b0;
    end
    if (rand_on) fifo_full = (fifo_q.size() >= FIFO_DEPTH) || ($urandom_range(4, 0) == 0);
    #1;
    if (fifo_full) check("wr_while_full", 64'(fifo_wr), 64'(0));
    if (fifo_wr) fifo_q.push_back(fifo_din);
    for (int p = 0; p < NUM_REQ; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        void'(src_q[p].pop_front());
        void'(src_last_q[p].pop_front());
        void'(src_first_q[p].pop_front());
      end
    end
    if (rand_on && fifo_q.size() > 0 && $urandom_range(1, 0) == 1) begin
      rd_word = fifo_q.pop_front();
      if (exp_q.size() == 0) check("rd_extra", 64'(1), 64'(0));
      else check("rd_data", 64'(rd_word), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!all_empty() && n < 50) begin
      step();
      n++;
    end
    check("drain_done", 64'(all_empty()), 64'(1));
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            seq_port[5] = '{0, 1, 2, 3, 0};
    int            seq_pkt[5]  = '{0, 0, 0, 0, 1};
    logic [3:0]    er;
    int            n_pkts = 0;
    int            n_words = 0;
    int            pk[NUM_REQ] = '{default: 0};
    int            cyc = 0;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) hold[p] = 1'b0;

    // Reset with every port valid; then 1-word packets rotate 0,1,2,3,0.
    for (int p = 0; p < NUM_REQ; p++) push_pkt(p, 0, 1, 1'b0);
    push_pkt(0, 1, 1, 1'b0);
    rst_cmd = 1'b1;
    step();
    step();
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_wr", 64'(fifo_wr), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pkt", 64'(pkt_count), 64'(0));
    rst_cmd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      er = '0;
      if (k % 2 == 1) er[seq_port[k/2]] = 1'b1;
      check("rr_wr", 64'(fifo_wr), 64'(k % 2));
      check("rr_ready", 64'(req_ready), 64'(er));
      check("rr_din", 64'(fifo_din), (k % 2 == 1) ? 64'(word(seq_port[k/2], seq_pkt[k/2], 0)) : 64'(0));
    end
    drain();
    check("rr_pkt", 64'(pkt_count), 64'(5));
    check("rr_busy", 64'(busy), 64'(0));

    // Port 2 packet stays contiguous while port 1 waits.
    fifo_q.delete();
    push_pkt(2, 1, 3, 1'b0);
    step();
    push_pkt(1, 1, 1, 1'b0);
    drain();
    check("atom_len", 64'(fifo_q.size()), 64'(4));
    for (int i = 0; i < 3; i++) check("atom_a", 64'(fifo_q[i]), 64'(word(2, 1, i)));
    check("atom_b", 64'(fifo_q[3]), 64'(word(1, 1, 0)));
    check("atom_pkt", 64'(pkt_count), 64'(7));

    // FIFO full for four cycles mid-packet.
    fifo_q.delete();
    push_pkt(0, 2, 4, 1'b0);
    step();
    step();
    check("full_w0", 64'(fifo_din), 64'(word(0, 2, 0)));
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("full_ready", 64'(req_ready), 64'(0));
      check("full_grant", 64'(grant_id), 64'(0));
      check("full_busy", 64'(busy), 64'(1));
    end
    fifo_full = 1'b0;
    drain();
    check("full_len", 64'(fifo_q.size()), 64'(4));
    for (int i = 0; i < 4; i++) check("full_data", 64'(fifo_q[i]), 64'(word(0, 2, i)));

    // Owner (port 1) goes quiet for three cycles while port 3 waits.
    fifo_q.delete();
    push_pkt(1, 5, 3, 1'b0);
    push_pkt(3, 5, 1, 1'b0);
    step();
    step();
    check("gap_grant", 64'(grant_id), 64'(1));
    hold[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_ready", 64'(req_ready), 64'(4'b0010));
      check("gap_wr", 64'(fifo_wr), 64'(0));
    end
    hold[1] = 1'b0;
    drain();
    check("gap_len", 64'(fifo_q.size()), 64'(4));
    for (int i = 0; i < 3; i++) check("gap_x", 64'(fifo_q[i]), 64'(word(1, 5, i)));
    check("gap_y", 64'(fifo_q[3]), 64'(word(3, 5, 0)));
    check("gap_pkt", 64'(pkt_count), 64'(10));

    // Reset pulsed mid-packet on port 1; port 0 wins the next grant.
    fifo_q.delete();
    push_pkt(1, 9, 3, 1'b0);
    step();
    step();
    check("mid_w0", 64'(fifo_din), 64'(word(1, 9, 0)));
    push_pkt(0, 9, 1, 1'b0);
    rst_cmd = 1'b1;
    step();
    check("mid_rst_wr", 64'(fifo_wr), 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    rst_cmd = 1'b0;
    step();
    check("post_busy", 64'(busy), 64'(0));
    check("post_pkt", 64'(pkt_count), 64'(0));
    check("post_wr", 64'(fifo_wr), 64'(0));
    step();
    check("post_grant", 64'(grant_id), 64'(0));
    check("post_din", 64'(fifo_din), 64'(word(0, 9, 0)));
    drain();
    check("post_pkt2", 64'(pkt_count), 64'(2));

    // Random full/read FIFO model, every port always has a packet pending.
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    step();
    fifo_q.delete();
    exp_q.delete();
    while (n_words < RAND_WORDS) begin
      int p;
      int len;
      p   = n_pkts % NUM_REQ;
      len = int'($urandom_range(4, 1));
      push_pkt(p, pk[p], len, 1'b1);
      pk[p]++;
      n_pkts++;
      n_words += len;
    end
    rand_on = 1'b1;
    while (exp_q.size() > 0 && cyc < 20000) begin
      step();
      cyc++;
    end
    rand_on   = 1'b0;
    fifo_full = 1'b0;
    step();
    check("rand_done", 64'(exp_q.size()), 64'(0));
    check("rand_left", 64'(fifo_q.size()), 64'(0));
    check("rand_pkt", 64'(pkt_count), 64'(n_pkts));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of producer ports (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-producer word valid.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed words, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port req_last  input  NUM_REQ  per-producer last word of packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-producer word accepted this cycle when valid.
REQ-009 SHALL have port fifo_full  input  1  shared FIFO full flag.
REQ-010 SHALL have port fifo_wr  output  1  shared FIFO write strobe.
REQ-011 SHALL have port fifo_din  output  DATA_WIDTH  shared FIFO write data.
REQ-012 SHALL have port grant_id  output  3  registered index of current owner.
REQ-013 SHALL have port busy  output  1  registered, high while in GRANT.
REQ-014 SHALL have port pkt_count  output  16  registered count of completed packets, wraps at 2^16.

Function
REQ-015 SHALL implement FSM with states IDLE and GRANT.
REQ-016 SHALL, in IDLE with any req_valid high, pick the first requester with req_valid high, scanning round-robin from (last_owner+1) mod NUM_REQ, and register it into grant_id, entering GRANT at the next edge.
REQ-017 SHALL, in IDLE with no req_valid high, stay in IDLE; req_ready all zero; fifo_wr zero.
REQ-018 SHALL, in GRANT, drive req_ready[grant_id] = !fifo_full and all other req_ready bits zero, combinationally.
REQ-019 SHALL, in GRANT, drive fifo_wr = req_valid[grant_id] && !fifo_full and fifo_din = req_data[grant_id], combinationally; a transfer is a cycle with fifo_wr high.
REQ-020 SHALL never assert fifo_wr while fifo_full is high.
REQ-021 SHALL hold the grant across cycles where req_valid[grant_id] is low or fifo_full is high (packet atomicity; no timeout).
REQ-022 SHALL, on a transfer with req_last[grant_id] high, return to IDLE at that edge, set last_owner = grant_id, and increment pkt_count.
REQ-023 SHALL therefore insert exactly one idle cycle between packets; first word of a granted packet transfers no earlier than one cycle after arbitration.
REQ-024 SHALL ignore req_last on non-transfer cycles.
REQ-025 SHALL leave fifo_din at zero when fifo_wr is low outside GRANT (don't-care inside GRANT).

Reset
REQ-026 SHALL, with rst high at an edge, force state IDLE, grant_id 0, busy 0, pkt_count 0, last_owner NUM_REQ-1 (requester 0 highest priority first).
REQ-027 SHALL, on reset during GRANT, abandon the partial packet; no further fifo_wr until a new grant.
REQ-028 SHALL hold req_ready and fifo_wr low while rst is high.

Structure
REQ-029 SHALL put the FSM state encoding and the grant_id width constant in a shared package fifo_arb_pkg.
REQ-030 SHALL implement round-robin selection as sub-module rr_pick (combinational: request vector, last_owner -> valid, index).

Verification
REQ-031 SHALL cover: after reset, all four ports valid, 1-word packets (last=1) -> fifo_wr order 0,1,2,3,0, one idle cycle between, pkt_count=5.
REQ-032 SHALL cover: port 2 sends 3-word packet A0,A1,A2 while port 1 requests -> FIFO sees A0,A1,A2 contiguous before any port-1 word.
REQ-033 SHALL cover: fifo_full held high 4 cycles mid-packet -> fifo_wr=0 and req_ready=0 those cycles, no data loss, grant kept.
REQ-034 SHALL cover: owner drops req_valid 3 cycles mid-packet while port 3 valid -> port 3 gets no req_ready until owner sends last.
REQ-035 SHALL cover: rst pulsed mid-packet on port 1 -> next grant goes to port 0 if valid, pkt_count=0.
REQ-036 SHALL cover: non-lookahead FIFO model with random full and random reads, 1000 words -> read stream equals per-port packets in arbitration order, no error.
